// File: rtl/rx_hold_fifo_pkt_if.sv
// Write/read handshake bundle for the frame-aware RX hold FIFO.
// slave is the FIFO side. master is the side that drives writes and reads,
// which is the decode pipeline plus the dequeue logic, or a testbench.
interface rx_hold_fifo_pkt_if #(
  parameter int DWIDTH = 64,
  parameter int SWIDTH = 8,
  parameter int AWIDTH = 4
);
  logic [DWIDTH-1:0] rxhfifo_wdata;
  logic [SWIDTH-1:0] rxhfifo_wstatus;
  logic              rxhfifo_wen;
  logic              rxhfifo_wcommit;
  logic              rxhfifo_wdrop;
  logic              rxhfifo_ren;
  logic [DWIDTH-1:0] rxhfifo_rdata;
  logic [SWIDTH-1:0] rxhfifo_rstatus;
  logic              rxhfifo_rempty;
  logic              rxhfifo_ralmost_empty;
  logic              rxhfifo_wfull;
  logic              rxhfifo_walmost_full;
  logic [AWIDTH:0]   rxhfifo_rlevel;
  logic              rxhfifo_ovflow;

  modport slave (
    input  rxhfifo_wdata, rxhfifo_wstatus, rxhfifo_wen, rxhfifo_wcommit,
           rxhfifo_wdrop, rxhfifo_ren,
    output rxhfifo_rdata, rxhfifo_rstatus, rxhfifo_rempty, rxhfifo_ralmost_empty,
           rxhfifo_wfull, rxhfifo_walmost_full, rxhfifo_rlevel, rxhfifo_ovflow
  );

  modport master (
    output rxhfifo_wdata, rxhfifo_wstatus, rxhfifo_wen, rxhfifo_wcommit,
           rxhfifo_wdrop, rxhfifo_ren,
    input  rxhfifo_rdata, rxhfifo_rstatus, rxhfifo_rempty, rxhfifo_ralmost_empty,
           rxhfifo_wfull, rxhfifo_walmost_full, rxhfifo_rlevel, rxhfifo_ovflow
  );
endinterface

// File: rtl/rx_hold_fifo_pkt.sv
// Frame-aware RX hold FIFO. Words are written speculatively behind wr_ptr.
// They only become readable once the writer commits the frame, which moves
// cm_ptr up to wr_ptr. A drop rewinds wr_ptr back to cm_ptr.
// An overflow poisons the current frame, so its later commit turns into a drop.
// All status outputs are registered from the next-state pointers.
module rx_hold_fifo_pkt #(
  parameter int DWIDTH              = 64,
  parameter int SWIDTH              = 8,
  parameter int AWIDTH              = 4,
  parameter int ALMOST_EMPTY_THRESH = 7,
  parameter int ALMOST_FULL_THRESH  = 12
) (
  input  logic                clk_xgmii_rx,
  input  logic                reset_xgmii_rx,
  rx_hold_fifo_pkt_if.slave   rx
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam int WW    = DWIDTH + SWIDTH;

  typedef logic [AWIDTH:0] ptr_t;

  localparam ptr_t FULL_LVL = ptr_t'(DEPTH);
  localparam ptr_t AE_LVL   = ptr_t'(ALMOST_EMPTY_THRESH);
  localparam ptr_t AF_LVL   = ptr_t'(ALMOST_FULL_THRESH);

  // Storage word: status sits above data.
  logic [WW-1:0] mem [DEPTH];

  ptr_t wr_ptr, cm_ptr, rd_ptr;
  ptr_t wr_nxt, cm_nxt, rd_nxt;
  ptr_t wlvl_nxt, rlvl_nxt;
  logic poison;
  logic wr_ok, rd_ok, ovf_now, do_drop, do_commit;

  // Next-state pointer arithmetic for this cycle's write, commit, drop and read.
  always_comb begin
    ovf_now   = rx.rxhfifo_wen & rx.rxhfifo_wfull;
    wr_ok     = rx.rxhfifo_wen & ~rx.rxhfifo_wfull;
    rd_ok     = rx.rxhfifo_ren & ~rx.rxhfifo_rempty;
    // A poisoned or overflowing frame can never be committed.
    do_drop   = rx.rxhfifo_wdrop | (rx.rxhfifo_wcommit & (poison | ovf_now));
    do_commit = rx.rxhfifo_wcommit & ~do_drop;
    wr_nxt    = do_drop ? cm_ptr : wr_ptr + ptr_t'(wr_ok);
    // The commit covers any word written in this same cycle.
    cm_nxt    = do_commit ? wr_nxt : cm_ptr;
    rd_nxt    = rd_ptr + ptr_t'(rd_ok);
    wlvl_nxt  = wr_nxt - rd_nxt;
    rlvl_nxt  = cm_nxt - rd_nxt;
  end

  // Pointer and poison state.
  always_ff @(posedge clk_xgmii_rx or posedge reset_xgmii_rx) begin
    if (reset_xgmii_rx) begin
      wr_ptr <= '0;
      cm_ptr <= '0;
      rd_ptr <= '0;
      poison <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      cm_ptr <= cm_nxt;
      rd_ptr <= rd_nxt;
      // Any frame end (commit or drop) starts the next frame clean.
      if (rx.rxhfifo_wcommit | rx.rxhfifo_wdrop) poison <= 1'b0;
      else if (ovf_now)                          poison <= 1'b1;
    end
  end

  // Registered status flags, computed from the post-edge pointers.
  always_ff @(posedge clk_xgmii_rx or posedge reset_xgmii_rx) begin
    if (reset_xgmii_rx) begin
      rx.rxhfifo_rempty        <= 1'b1;
      rx.rxhfifo_ralmost_empty <= 1'b1;
      rx.rxhfifo_wfull         <= 1'b0;
      rx.rxhfifo_walmost_full  <= 1'b0;
      rx.rxhfifo_rlevel        <= '0;
      rx.rxhfifo_ovflow        <= 1'b0;
    end else begin
      rx.rxhfifo_rempty        <= (rlvl_nxt == '0);
      rx.rxhfifo_ralmost_empty <= (rlvl_nxt <= AE_LVL);
      rx.rxhfifo_wfull         <= (wlvl_nxt == FULL_LVL);
      rx.rxhfifo_walmost_full  <= (wlvl_nxt >= AF_LVL);
      rx.rxhfifo_rlevel        <= rlvl_nxt;
      rx.rxhfifo_ovflow        <= ovf_now;
    end
  end

  // Read port. It updates only on an accepted read and holds otherwise.
  always_ff @(posedge clk_xgmii_rx or posedge reset_xgmii_rx) begin
    if (reset_xgmii_rx) begin
      rx.rxhfifo_rdata   <= '0;
      rx.rxhfifo_rstatus <= '0;
    end else if (rd_ok) begin
      {rx.rxhfifo_rstatus, rx.rxhfifo_rdata} <= mem[rd_ptr[AWIDTH-1:0]];
    end
  end

  // Storage write. It is not reset. Dropped words are simply overwritten later.
  // Writes land in the uncommitted region, so they never hit the read address.
  always_ff @(posedge clk_xgmii_rx) begin
    if (wr_ok) mem[wr_ptr[AWIDTH-1:0]] <= {rx.rxhfifo_wstatus, rx.rxhfifo_wdata};
  end

endmodule

// File: tb/tb_rx_hold_fifo_pkt.sv
// Bench for rx_hold_fifo_pkt. A queue-based frame model holds committed and
// pending frame words. Directed scenarios run first, then a random traffic mix.
module tb_rx_hold_fifo_pkt;
  localparam int DW = 64, SW = 8, AW = 4, DEPTH = 16, AE = 7, AF = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rx_hold_fifo_pkt_if #(.DWIDTH(DW), .SWIDTH(SW), .AWIDTH(AW)) rx ();

  rx_hold_fifo_pkt #(
    .DWIDTH(DW), .SWIDTH(SW), .AWIDTH(AW),
    .ALMOST_EMPTY_THRESH(AE), .ALMOST_FULL_THRESH(AF)
  ) dut (
    .clk_xgmii_rx  (clk),
    .reset_xgmii_rx(rst),
    .rx            (rx)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: committed words, the pending frame, and the read-port value.
  logic [SW+DW-1:0] cq[$];
  logic [SW+DW-1:0] pq[$];
  bit               m_poison;
  bit               m_ovf;
  logic [DW-1:0]    m_rdata;
  logic [SW-1:0]    m_rstat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    cq.delete();
    pq.delete();
    m_poison = 1'b0;
    m_ovf    = 1'b0;
    m_rdata  = '0;
    m_rstat  = '0;
  endtask

  task automatic check_all(input string ctx);
    int tot;
    tot = cq.size() + pq.size();
    chk({ctx, ".rempty"},   64'(rx.rxhfifo_rempty),        64'(cq.size() == 0));
    chk({ctx, ".ralmost"},  64'(rx.rxhfifo_ralmost_empty), 64'(cq.size() <= AE));
    chk({ctx, ".wfull"},    64'(rx.rxhfifo_wfull),         64'(tot == DEPTH));
    chk({ctx, ".walmost"},  64'(rx.rxhfifo_walmost_full),  64'(tot >= AF));
    chk({ctx, ".rlevel"},   64'(rx.rxhfifo_rlevel),        64'(cq.size()));
    chk({ctx, ".ovflow"},   64'(rx.rxhfifo_ovflow),        64'(m_ovf));
    chk({ctx, ".rdata"},    rx.rxhfifo_rdata,              m_rdata);
    chk({ctx, ".rstatus"},  64'(rx.rxhfifo_rstatus),       64'(m_rstat));
  endtask

  // One clock: drive at the negedge, advance the model, check at the next negedge.
  task automatic step(input string ctx, input bit wen, input bit wc, input bit wd, input bit ren);
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    bit full, ovf, drop;
    d = {$urandom, $urandom};
    s = SW'($urandom);
    rx.rxhfifo_wdata   = d;
    rx.rxhfifo_wstatus = s;
    rx.rxhfifo_wen     = wen;
    rx.rxhfifo_wcommit = wc;
    rx.rxhfifo_wdrop   = wd;
    rx.rxhfifo_ren     = ren;

    full = (cq.size() + pq.size()) == DEPTH;
    ovf  = wen && full;
    if (ren && cq.size() != 0) {m_rstat, m_rdata} = cq.pop_front();
    if (wen && !full) pq.push_back({s, d});
    drop = wd || (wc && (m_poison || ovf));
    if (drop) pq.delete();
    else if (wc) begin
      foreach (pq[i]) cq.push_back(pq[i]);
      pq.delete();
    end
    m_poison = (wc || wd) ? 1'b0 : (m_poison || ovf);
    m_ovf    = ovf;

    @(negedge clk);
    check_all(ctx);
  endtask

  initial begin
    rst = 1'b1;
    rx.rxhfifo_wdata = '0; rx.rxhfifo_wstatus = '0; rx.rxhfifo_wen = 0;
    rx.rxhfifo_wcommit = 0; rx.rxhfifo_wdrop = 0; rx.rxhfifo_ren = 0;
    model_reset();
    @(negedge clk);
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // 5-word frame committed on the last word, then drained.
    for (int i = 0; i < 5; i++) step("f5w", 1, i == 4, 0, 0);
    step("f5idle", 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step("f5r", 0, 0, 0, 1);

    // Uncommitted words are invisible. A drop rewinds them.
    for (int i = 0; i < 3; i++) step("unc_w", 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) step("unc_r", 0, 0, 0, 1);
    step("unc_drop", 0, 0, 1, 0);
    step("unc_next", 1, 1, 0, 0);
    step("unc_rd", 0, 0, 0, 1);

    // Fill to full, overflow once, then the poisoned commit acts as a drop.
    for (int i = 0; i < DEPTH; i++) step("fill", 1, 0, 0, 0);
    step("ovf", 1, 0, 0, 0);
    step("ovf_idle", 0, 0, 0, 0);
    step("ovf_commit", 0, 1, 0, 0);
    step("ovf_after", 1, 1, 0, 0);
    step("ovf_rd", 0, 0, 0, 1);

    // Full with everything committed, including overflow with a same-cycle commit.
    for (int i = 0; i < DEPTH; i++) step("fullc", 1, i == DEPTH - 1, 0, 0);
    step("fullc_ovf", 1, 1, 0, 0);
    for (int i = 0; i < DEPTH + 1; i++) step("fullc_rd", 0, 0, 0, 1);

    // Frame A committed, frame B dropped, then read A back.
    for (int i = 0; i < 4; i++) step("fa", 1, i == 3, 0, 0);
    step("fb0", 1, 0, 0, 0);
    step("fb1", 1, 0, 1, 0);
    for (int i = 0; i < 5; i++) step("fab_rd", 0, 0, 0, 1);

    // Single-word commits streaming while reading every cycle.
    for (int i = 0; i < 40; i++) step("stream", 1, 1, 0, 1);
    step("stream_end", 0, 0, 0, 1);

    // Reset mid-frame: 6 committed plus 3 pending.
    for (int i = 0; i < 6; i++) step("mr_c", 1, i == 5, 0, 0);
    for (int i = 0; i < 3; i++) step("mr_u", 1, 0, 0, 0);
    rst = 1'b1;
    rx.rxhfifo_wen = 0; rx.rxhfifo_wcommit = 0; rx.rxhfifo_ren = 0;
    #2;
    model_reset();
    check_all("midreset");
    @(negedge clk);
    check_all("midreset_hold");
    rst = 1'b0;
    step("mr_w", 1, 1, 0, 0);
    step("mr_rd", 0, 0, 0, 1);

    // Random traffic mix.
    for (int i = 0; i < 3000; i++)
      step("rand", $urandom_range(0, 9) < 6, $urandom_range(0, 19) < 3,
           $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
